multiplier: RTL and testbench
=============================

# multiplier

Sequential 32×32-bit integer multiplier for the laRVa2 RISC-V core, serving the M-extension MUL/MULH/MULHU/MULHSU instructions. Each operand is independently signed or unsigned, and a single 32-bit half of the 64-bit product is returned. It processes one 4-bit digit of the multiplier per clock, so it finishes in a fixed 8 cycles after a load, with a busy/load handshake to the pipeline.

## Interface
Parameters:
- none. Widths are fixed by package constants: WIDTH = 32, DIGIT = 4, STEPS = 8.

Ports:
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `a`  in  32  multiplicand.
- `b`  in  32  multiplier.
- `ua`  in  1  1 = treat `a` as unsigned; 0 = treat `a` as two's complement.
- `ub`  in  1  1 = treat `b` as unsigned; 0 = treat `b` as two's complement.
- `hm`  in  1  1 = return product[63:32]; 0 = return product[31:0].
- `load`  in  1  start request, sampled on a rising edge of `clk`.
- `busy`  out  1  high while an operation is in progress.
- `out`  out  32  selected half of the last completed product.

## Operation
- **States:** IDLE and RUN. A 3-bit step counter runs 0..7 during RUN.
- **IDLE → RUN:** on a rising edge with `load`=1 and `busy`=0.
  - Capture a 33-bit extended `a`: sign bit = `~ua & a[31]`.
  - Capture `b`, `ub` and `hm`.
  - Clear the accumulator and the counter.
  - Set `busy`=1.
- **`load` while `busy`=1:** ignored; the running operation is unaffected.
- **Each RUN step k (0..7):**
  - digit = `b[4k+3:4k]`, taken as unsigned for k<7.
  - For k=7 with `ub`=0, digit = `b[31:28] − 16·b[31]` (signed top digit).
  - Accumulator high part (37-bit signed) += extended `a` × digit.
  - Shift the 64-bit accumulator right arithmetically by 4; shifted-out bits fill the low word.
- **Completion:** after step 7 the accumulator equals the exact product `ext(a)·ext(b)` modulo 2^64.
  - `out` is loaded with [63:32] if the captured `hm`=1, else [31:0].
  - State → IDLE, `busy`=0.
- **Result hold:** `out` is a dedicated register written only at completion. It holds its value through later loads until the next completion.
- **Operand and `hm` changes:** changes to `a`, `b`, `ua`, `ub` or `hm` after the load edge have no effect on the running operation.

## Timing
- **Reset** (asynchronous, `reset`=0): state IDLE, `busy`=0, `out`=0, accumulator and counter 0.
- **Reset mid-operation:** aborts immediately. `out` reads 0 after release; no completion occurs.
- **Load edge:** at rising edge L with `load`=1, `busy` goes high right after L. It is therefore already 1 when `load` is lowered one cycle later.
- **Latency:**
  - Steps execute on edges L+1 … L+8.
  - `busy` falls and `out` updates together, immediately after edge L+8.
  - `busy` is high for exactly 8 cycles.
- **Valid result:** `out` is valid whenever `busy`=0 and at least one operation has completed.
- **Back-to-back:** a new load is accepted on edge L+9, the first edge with `busy`=0.

## Configuration
- **`MULT_DONE_EN` defined:** adds output `done` (1 bit).
  - `done` is a one-cycle pulse, high during the cycle after edge L+8, coincident with `busy` falling.
  - `done` is 0 at reset.
- **`MULT_DONE_EN` undefined:** no `done` port. The interface is exactly as listed above.

## Structure
- **Package `mult_pkg`:** WIDTH, DIGIT, STEPS constants; state enum (IDLE, RUN).
- **Sub-module `mult_digit_step`:**
  - Purely combinational.
  - Inputs: 37-bit accumulator high part, 33-bit extended `a`, 4-bit digit, signed-digit flag.
  - Output: next 37-bit sum.
- The top level holds the FSM, the counter, the operand/accumulator registers and the `out` register.

## Test plan
- **Small positives:** `a`=5, `b`=7, `ua`=`ub`=1, `hm`=0 → `out`=0x00000023, `busy` high exactly 8 cycles.
- **Mixed signedness:**
  - `a`=5, `b`=0xFFFFFFF9, `ua`=1, `ub`=0, `hm`=0 → 0xFFFFFFDD.
  - Same operands with `hm`=1 → 0xFFFFFFFF.
- **Both negative:** `a`=0xFFFFFFFB, `b`=0xFFFFFFF9, signed.
  - `hm`=1 → 0x00000000.
  - `hm`=0 → 0x00000023.
- **Extremes:**
  - 0xFFFFFFFF × 0xFFFFFFFF unsigned, `hm`=1 → 0xFFFFFFFE.
  - 0x80000000 × 0x80000000 signed, `hm`=1 → 0x40000000.
  - 0xFFFFFFFF (`ua`=1) × 0xFFFFFFFF (`ub`=0): `hm`=1 → 0xFFFFFFFF; `hm`=0 → 0x00000001.
- **Handshake:**
  - Load 3×4 unsigned. Assert `load` again at cycle 3 of the operation with `a`=9, `b`=9 → `out`=0x0000000C and `busy` still falls at L+8.
  - An immediate back-to-back load at L+9 is accepted.
- **Reset mid-operation:** drop `reset` at cycle 4 → `busy`=0 and `out`=0 at once. A subsequent 5×7 operation completes normally.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state type for the sequential radix-16 multiplier.
package mult_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DIGIT = 4;
  localparam int unsigned STEPS = 8;

  typedef enum logic {
    StIdle,
    StRun
  } mult_state_e;

endpackage

// File: rtl/mult_digit_step.sv
// One radix-16 step: adds extended multiplicand times a 4-bit digit to the
// 37-bit signed accumulator high part. The digit is signed only for the top
// digit of a signed multiplier.
module mult_digit_step
  import mult_pkg::*;
(
  input  logic [WIDTH+4:0] acc_hi,
  input  logic [WIDTH:0]   a_ext,
  input  logic [DIGIT-1:0] digit,
  input  logic             digit_signed,
  output logic [WIDTH+4:0] sum
);

  logic [DIGIT:0]   digit_ext;
  logic [WIDTH+4:0] a_sx;
  logic [WIDTH+4:0] d_sx;
  logic [WIDTH+4:0] prod;

  // Sign-extend both factors to the full sum width so the product is exact.
  always_comb begin
    digit_ext = {digit_signed & digit[DIGIT-1], digit};
    a_sx      = {{4{a_ext[WIDTH]}}, a_ext};
    d_sx      = {{(WIDTH + 5 - DIGIT - 1){digit_ext[DIGIT]}}, digit_ext};
    prod      = a_sx * d_sx;
    sum       = acc_hi + prod;
  end

endmodule

// File: rtl/multiplier.sv
// Sequential 32x32 multiplier for MUL/MULH/MULHU/MULHSU, one 4-bit digit of
// the multiplier per clock, 8 cycles per operation.
// Optional feature macro: MULT_DONE_EN adds a one-cycle 'done' pulse output.
module multiplier
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ua,
  input  logic             ub,
  input  logic             hm,
  input  logic             load,
  output logic             busy,
  output logic [WIDTH-1:0] out
`ifdef MULT_DONE_EN
  ,
  output logic             done
`endif
);

  mult_state_e      state_q;
  logic [2:0]       cnt_q;
  logic [WIDTH:0]   a_ext_q;
  logic [WIDTH-1:0] b_q;
  logic             ub_q;
  logic             hm_q;
  // High part kept 33 bits wide so unsigned x unsigned partials never overflow.
  logic [WIDTH:0]   acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] out_q;
  logic             busy_q;

  logic [WIDTH+4:0] acc_hi_sx;
  logic [WIDTH+4:0] step_sum;
  logic             last_step;
  logic [WIDTH:0]   next_hi;
  logic [WIDTH-1:0] next_lo;

  // Step datapath: current digit is always the low nibble of the shifting b_q.
  always_comb begin
    acc_hi_sx = {{4{acc_hi_q[WIDTH]}}, acc_hi_q};
    last_step = (cnt_q == 3'(STEPS - 1));
    next_hi   = step_sum[WIDTH+4:DIGIT];
    next_lo   = {step_sum[DIGIT-1:0], acc_lo_q[WIDTH-1:DIGIT]};
  end

  mult_digit_step u_step (
    .acc_hi       (acc_hi_sx),
    .a_ext        (a_ext_q),
    .digit        (b_q[DIGIT-1:0]),
    .digit_signed (last_step & ~ub_q),
    .sum          (step_sum)
  );

  // Control FSM, operand capture, accumulator and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_ext_q  <= '0;
      b_q      <= '0;
      ub_q     <= 1'b0;
      hm_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
`ifdef MULT_DONE_EN
      done     <= 1'b0;
`endif
    end else begin
`ifdef MULT_DONE_EN
      done <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (load) begin
            a_ext_q  <= {~ua & a[WIDTH-1], a};
            b_q      <= b;
            ub_q     <= ub;
            hm_q     <= hm;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_hi_q <= next_hi;
          acc_lo_q <= next_lo;
          b_q      <= b_q >> DIGIT;
          cnt_q    <= cnt_q + 3'd1;
          if (last_step) begin
            out_q   <= hm_q ? next_hi[WIDTH-1:0] : next_lo;
            busy_q  <= 1'b0;
            state_q <= StIdle;
`ifdef MULT_DONE_EN
            done    <= 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign out  = out_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the sequential multiplier.
module tb_multiplier;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        ua;
  logic        ub;
  logic        hm;
  logic        load;
  logic        busy;
  logic [31:0] out;
`ifdef MULT_DONE_EN
  logic        done;
`endif

  int unsigned n_checks;
  int unsigned n_fails;
  logic [31:0] prev_out;

  multiplier dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .ua    (ua),
    .ub    (ub),
    .hm    (hm),
    .load  (load),
    .busy  (busy),
    .out   (out)
`ifdef MULT_DONE_EN
    ,
    .done  (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after busy falls.
  // poke >= 0 re-asserts load with new operands at that cycle of the operation.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic iua, input logic iub, input logic ihm,
                        input logic [31:0] exp, input int poke);
    int cycles;
    a    = ia;
    b    = ib;
    ua   = iua;
    ub   = iub;
    hm   = ihm;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy after load"}, 32'(busy), 32'd1);
    check({tag, " out held"}, out, prev_out);
    // Operand changes after the load edge must not matter.
    a  = ~ia;
    b  = ib ^ 32'h5A5A_5A5A;
    ua = ~iua;
    ub = ~iub;
    hm = ~ihm;
    cycles = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == poke) begin
        load = 1'b1;
        a    = 32'd9;
        b    = 32'd9;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      if (busy) cycles++;
      else break;
    end
    load = 1'b0;
    check({tag, " busy cycles"}, 32'(cycles), 32'd8);
    check({tag, " result"}, out, exp);
`ifdef MULT_DONE_EN
    check({tag, " done pulse"}, 32'(done), 32'd1);
`endif
    prev_out = exp;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    prev_out = '0;
    reset = 1'b0;
    a = '0; b = '0; ua = 1'b0; ub = 1'b0; hm = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out", out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Consecutive calls load on the first edge with busy low (back-to-back).
    run_op("pos 5x7",      32'd5,          32'd7,          1'b1, 1'b1, 1'b0, 32'h0000_0023, -1);
    run_op("mix lo",       32'd5,          32'hFFFF_FFF9,  1'b1, 1'b0, 1'b0, 32'hFFFF_FFDD, -1);
    run_op("mix hi",       32'd5,          32'hFFFF_FFF9,  1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, -1);
    run_op("neg hi",       32'hFFFF_FFFB,  32'hFFFF_FFF9,  1'b0, 1'b0, 1'b1, 32'h0000_0000, -1);
    run_op("neg lo",       32'hFFFF_FFFB,  32'hFFFF_FFF9,  1'b0, 1'b0, 1'b0, 32'h0000_0023, -1);
    run_op("umax hi",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, -1);
    run_op("smin hi",      32'h8000_0000,  32'h8000_0000,  1'b0, 1'b0, 1'b1, 32'h4000_0000, -1);
    run_op("su hi",        32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, -1);
    run_op("su lo",        32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, 32'h0000_0001, -1);
    run_op("ffff sq",      32'h0000_FFFF,  32'h0000_FFFF,  1'b1, 1'b1, 1'b0, 32'hFFFE_0001, -1);
    run_op("m1 x smin lo", 32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b0, 1'b0, 32'h8000_0000, -1);
    run_op("load ignored", 32'd3,          32'd4,          1'b1, 1'b1, 1'b0, 32'h0000_000C, 2);
    run_op("back2back",    32'd6,          32'd7,          1'b1, 1'b1, 1'b0, 32'h0000_002A, -1);

    // Abort mid-operation with an asynchronous reset.
    a = 32'd5; b = 32'd7; ua = 1'b1; ub = 1'b1; hm = 1'b0; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort out", out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post-abort busy", 32'(busy), 32'd0);
    prev_out = '0;
    run_op("after abort",  32'd5,          32'd7,          1'b1, 1'b1, 1'b0, 32'h0000_0023, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
